dds_pulse_sequencer: RTL and testbench

Segment-table pulse sequencer that drives the frequency word of the DDS array and gates the transmit path for NMR excitation. A host loads up to N_SEG segments, each with a frequency, a duration and a gate bit, then issues `start`. The block waits for the DDS array to report valid output, then plays the segments back to back, repeating the whole list `n_rep` times. It sits between the host/config register bank and the DDS array's `frq` input, and drives the TX gate switch.

---
 rtl/dds_pulse_sequencer_if.sv | 40 ++++
 rtl/dds_pulse_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dds_pulse_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_pulse_sequencer_if.sv
// Host/DDS-side signal bundle of the pulse sequencer.
// master: host config + start/abort + DDS valid in, sequencer outputs observed.
// slave : the sequencer itself (drives frq, tx_gate, indices, busy, done).
interface dds_pulse_sequencer_if #(
  parameter int N_SEG = 8,
  parameter int FRQ_W = 32,
  parameter int DUR_W = 32,
  parameter int REP_W = 16
);
  localparam int SEG_W = $clog2(N_SEG);

  logic             cfg_we;
  logic [SEG_W-1:0] cfg_addr;
  logic [FRQ_W-1:0] cfg_frq;
  logic [DUR_W-1:0] cfg_dur;
  logic             cfg_gate;
  logic             cfg_last;
  logic [REP_W-1:0] n_rep;
  logic             start;
  logic             abort;
  logic             dds_val;
  logic [FRQ_W-1:0] frq;
  logic             tx_gate;
  logic [SEG_W-1:0] seg_idx;
  logic [REP_W-1:0] rep_idx;
  logic             busy;
  logic             done;

  modport master (
    output cfg_we, cfg_addr, cfg_frq, cfg_dur, cfg_gate, cfg_last,
    output n_rep, start, abort, dds_val,
    input  frq, tx_gate, seg_idx, rep_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_frq, cfg_dur, cfg_gate, cfg_last,
    input  n_rep, start, abort, dds_val,
    output frq, tx_gate, seg_idx, rep_idx, busy, done
  );
endinterface

// File: rtl/dds_pulse_sequencer.sv
// Segment-table pulse sequencer: plays up to N_SEG (frq, dur, gate) entries back
// to back n_rep times once the DDS array reports valid, driving frq and tx_gate.
// Ports: clk, rst (sync, active-high); bus = config/start/abort/dds_val in, frq/tx_gate/seg_idx/rep_idx/busy/done out.
module dds_pulse_sequencer #(
  parameter int N_SEG = 8,
  parameter int FRQ_W = 32,
  parameter int DUR_W = 32,
  parameter int REP_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dds_pulse_sequencer_if.slave  bus
);
  localparam int SEG_W = $clog2(N_SEG);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] rep_last_q, rep_last_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [FRQ_W-1:0] frq_q, frq_d;
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Segment table; deliberately not reset so a reset keeps the loaded program.
  logic [FRQ_W-1:0] tbl_frq [N_SEG];
  logic [DUR_W-1:0] tbl_dur [N_SEG];
  logic [N_SEG-1:0] tbl_gate;
  logic [N_SEG-1:0] tbl_last;

  logic             tbl_wr;
  logic [FRQ_W-1:0] ent0_frq;
  logic             seg_final;
  logic [SEG_W-1:0] seg_nxt;

  // Writes only land in IDLE; abort and reset take priority over them.
  assign tbl_wr = bus.cfg_we && (state_q == S_IDLE) && !bus.abort && !rst;

  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      tbl_frq[bus.cfg_addr]  <= bus.cfg_frq;
      tbl_dur[bus.cfg_addr]  <= bus.cfg_dur;
      tbl_gate[bus.cfg_addr] <= bus.cfg_gate;
      tbl_last[bus.cfg_addr] <= bus.cfg_last;
    end
  end

  // A write to entry 0 in the start cycle must already show up in ARM's frq.
  assign ent0_frq  = (tbl_wr && bus.cfg_addr == '0) ? bus.cfg_frq : tbl_frq[0];
  assign seg_final = tbl_last[seg_q] || (seg_q == SEG_W'(N_SEG - 1));
  assign seg_nxt   = seg_q + SEG_W'(1);

  // Counter holds remaining cycles minus one, so a zero duration plays once.
  function automatic logic [DUR_W-1:0] dur_m1(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    rep_d      = rep_q;
    rep_last_d = rep_last_q;
    cnt_d      = cnt_q;
    frq_d      = frq_q;
    gate_d     = gate_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
      frq_d   = '0;
      gate_d  = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d    = S_ARM;
            seg_d      = '0;
            rep_d      = '0;
            rep_last_d = (bus.n_rep == '0) ? '0 : bus.n_rep - REP_W'(1);
            cnt_d      = '0;
            frq_d      = ent0_frq;
            gate_d     = 1'b0;
            busy_d     = 1'b1;
          end
        end
        S_ARM: begin
          if (bus.dds_val) begin
            state_d = S_RUN;
            frq_d   = tbl_frq[0];
            gate_d  = tbl_gate[0];
            cnt_d   = dur_m1(tbl_dur[0]);
          end
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DUR_W'(1);
          end else if (!seg_final) begin
            seg_d  = seg_nxt;
            frq_d  = tbl_frq[seg_nxt];
            gate_d = tbl_gate[seg_nxt];
            cnt_d  = dur_m1(tbl_dur[seg_nxt]);
          end else if (rep_q != rep_last_q) begin
            seg_d  = '0;
            rep_d  = rep_q + REP_W'(1);
            frq_d  = tbl_frq[0];
            gate_d = tbl_gate[0];
            cnt_d  = dur_m1(tbl_dur[0]);
          end else begin
            state_d = S_DONE;
            frq_d   = '0;
            gate_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          frq_d   = '0;
          gate_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      seg_q      <= '0;
      rep_q      <= '0;
      rep_last_q <= '0;
      cnt_q      <= '0;
      frq_q      <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      rep_q      <= rep_d;
      rep_last_q <= rep_last_d;
      cnt_q      <= cnt_d;
      frq_q      <= frq_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.frq     = frq_q;
  assign bus.tx_gate = gate_q;
  assign bus.seg_idx = seg_q;
  assign bus.rep_idx = rep_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_dds_pulse_sequencer.sv
module tb_dds_pulse_sequencer;
  localparam int N_SEG = 8;
  localparam int FRQ_W = 32;
  localparam int DUR_W = 32;
  localparam int REP_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_pulse_sequencer_if #(.N_SEG(N_SEG), .FRQ_W(FRQ_W), .DUR_W(DUR_W), .REP_W(REP_W)) bus();

  dds_pulse_sequencer #(.N_SEG(N_SEG), .FRQ_W(FRQ_W), .DUR_W(DUR_W), .REP_W(REP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] frq;
    logic        gate;
    int          seg;
    int          rep;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int n_busy, n_gate, n_done;

  // Shadow of what the table should hold, following the write-acceptance rules.
  logic [31:0] sh_frq [N_SEG];
  int          sh_dur [N_SEG];
  bit          sh_gate[N_SEG];
  bit          sh_last[N_SEG];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [31:0] f, input logic g, input int s,
                                   input int r, input logic b, input logic d);
    exp_t e;
    e.frq = f; e.gate = g; e.seg = s; e.rep = r; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endfunction

  // Single compare process: one expected entry per cycle while a run is in flight.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("frq",     64'(bus.frq),     64'(e.frq));
      chk("tx_gate", 64'(bus.tx_gate), 64'(e.gate));
      chk("busy",    64'(bus.busy),    64'(e.busy));
      chk("done",    64'(bus.done),    64'(e.done));
      chk("seg_idx", 64'(bus.seg_idx), 64'(e.seg));
      chk("rep_idx", 64'(bus.rep_idx), 64'(e.rep));
      if (bus.busy === 1'b1)    n_busy++;
      if (bus.tx_gate === 1'b1) n_gate++;
      if (bus.done === 1'b1)    n_done++;
    end
  end

  task automatic write_entry(input int a, input logic [31:0] f, input int d, input bit g, input bit l);
    @(posedge clk); #1;
    bus.cfg_addr = 3'(a);
    bus.cfg_frq  = f;
    bus.cfg_dur  = 32'(d);
    bus.cfg_gate = g;
    bus.cfg_last = l;
    bus.cfg_we   = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    sh_frq[a] = f; sh_dur[a] = d; sh_gate[a] = g; sh_last[a] = l;
  endtask

  task automatic load_basic();
    write_entry(0, 32'd1_000_000, 4,  1'b1, 1'b0);
    write_entry(1, 32'd2_000_000, 10, 1'b0, 1'b0);
    write_entry(2, 32'd3_000_000, 6,  1'b1, 1'b1);
  endtask

  // w: ARM cycles with dds_val low; abort_after: RUN cycles before abort (-1 = none);
  // wr_in_run: attempt a table write during RUN; new0: nonzero = write entry 0 with start.
  task automatic run(input int nrep, input int w, input int abort_after,
                     input bit wr_in_run, input logic [31:0] new0);
    int nr, last_s, total, cnt, e_seg, e_rep;
    n_busy = 0; n_gate = 0; n_done = 0;
    @(posedge clk); #1;
    bus.n_rep   = 16'(nrep);
    bus.start   = 1'b1;
    bus.dds_val = (w == 0);
    if (new0 != 0) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_frq = new0;
      bus.cfg_dur = 32'(sh_dur[0]); bus.cfg_gate = sh_gate[0]; bus.cfg_last = sh_last[0];
      sh_frq[0] = new0;
    end
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    bus.n_rep  = 16'hFFFF;   // must not matter once latched

    nr = (nrep == 0) ? 1 : nrep;
    last_s = 0;
    while (!sh_last[last_s] && last_s < N_SEG - 1) last_s++;
    for (int i = 0; i <= w; i++) push_exp(sh_frq[0], 1'b0, 0, 0, 1'b1, 1'b0);
    cnt = 0; e_seg = 0; e_rep = 0;
    for (int r = 0; r < nr; r++)
      for (int s = 0; s <= last_s; s++)
        for (int d = 0; d < ((sh_dur[s] == 0) ? 1 : sh_dur[s]); d++)
          if (abort_after < 0 || cnt < abort_after) begin
            push_exp(sh_frq[s], sh_gate[s], s, r, 1'b1, 1'b0);
            cnt++; e_seg = s; e_rep = r;
          end
    if (abort_after >= 0) begin
      push_exp(32'd0, 1'b0, e_seg, e_rep, 1'b0, 1'b0);
      push_exp(32'd0, 1'b0, e_seg, e_rep, 1'b0, 1'b0);
    end else begin
      push_exp(32'd0, 1'b0, last_s, nr - 1, 1'b0, 1'b1);
      push_exp(32'd0, 1'b0, last_s, nr - 1, 1'b0, 1'b0);
    end
    total = exp_q.size();

    for (int c = 1; c <= total + 2; c++) begin
      @(posedge clk); #1;
      if (c == w) bus.dds_val = 1'b1;
      if (c == w + 3) bus.dds_val = 1'b0;   // dropout while running
      if (abort_after >= 0 && c == w + abort_after) begin
        bus.abort = 1'b1; bus.start = 1'b1;
      end
      if (abort_after >= 0 && c == w + abort_after + 1) begin
        bus.abort = 1'b0; bus.start = 1'b0;
      end
      if (wr_in_run && c == w + 2) begin
        bus.cfg_addr = 3'd1; bus.cfg_frq = 32'hDEAD_BEEF; bus.cfg_dur = 32'd99;
        bus.cfg_gate = 1'b1; bus.cfg_last = 1'b1; bus.cfg_we = 1'b1;
      end
      if (wr_in_run && c == w + 3) bus.cfg_we = 1'b0;
    end
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_frq = 0; bus.cfg_dur = 0;
    bus.cfg_gate = 0; bus.cfg_last = 0; bus.n_rep = 0; bus.start = 0;
    bus.abort = 0; bus.dds_val = 0;
    for (int i = 0; i < N_SEG; i++) begin
      sh_frq[i] = 0; sh_dur[i] = 0; sh_gate[i] = 0; sh_last[i] = 0;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_frq", 64'(bus.frq), 64'd0);
    chk("rst_gate", 64'(bus.tx_gate), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_seg", 64'(bus.seg_idx), 64'd0);
    chk("rst_rep", 64'(bus.rep_idx), 64'd0);

    // Three-segment program, single pass: 1 ARM + 20 RUN cycles.
    load_basic();
    run(1, 0, -1, 1'b0, 32'd0);
    chk("t1_busy_cycles", 64'(n_busy), 64'd21);
    chk("t1_gate_cycles", 64'(n_gate), 64'd10);
    chk("t1_done_pulses", 64'(n_done), 64'd1);

    // Three repetitions: 60 RUN cycles, single done.
    run(3, 0, -1, 1'b0, 32'd0);
    chk("t2_busy_cycles", 64'(n_busy), 64'd61);
    chk("t2_gate_cycles", 64'(n_gate), 64'd30);
    chk("t2_done_pulses", 64'(n_done), 64'd1);

    // No last flag: index walks all 8 entries, 16 RUN cycles.
    for (int i = 0; i < N_SEG; i++) write_entry(i, 32'(100 + i), 2, bit'(i % 2), 1'b0);
    run(1, 0, -1, 1'b0, 32'd0);
    chk("t3_busy_cycles", 64'(n_busy), 64'd17);
    chk("t3_gate_cycles", 64'(n_gate), 64'd8);

    // Zero durations and n_rep=0: five one-cycle segments, one pass.
    for (int i = 0; i < N_SEG; i++) write_entry(i, 32'(500 + i), 0, bit'(i < 3), bit'(i == 4));
    run(0, 0, -1, 1'b0, 32'd0);
    chk("t4_busy_cycles", 64'(n_busy), 64'd6);
    chk("t4_done_pulses", 64'(n_done), 64'd1);

    // DDS not ready for 50 cycles: ARM holds.
    load_basic();
    run(1, 50, -1, 1'b0, 32'd0);
    chk("t5_busy_cycles", 64'(n_busy), 64'd71);
    chk("t5_gate_cycles", 64'(n_gate), 64'd10);

    // Abort mid segment 1 with a concurrent start; a write during RUN is dropped.
    run(1, 0, 7, 1'b1, 32'd0);
    chk("t6_busy_cycles", 64'(n_busy), 64'd8);
    chk("t6_done_pulses", 64'(n_done), 64'd0);

    // Rerun: table must be unchanged by the RUN-time write.
    run(1, 0, -1, 1'b0, 32'd0);
    chk("t7_gate_cycles", 64'(n_gate), 64'd10);
    chk("t7_done_pulses", 64'(n_done), 64'd1);

    // Write to entry 0 in the start cycle is used immediately.
    run(1, 0, -1, 1'b0, 32'd5_000_000);
    chk("t8_busy_cycles", 64'(n_busy), 64'd21);

    // Reset mid-RUN clears state and outputs but keeps the table.
    @(posedge clk); #1;
    bus.n_rep = 16'd1; bus.start = 1'b1; bus.dds_val = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t9_busy_before_rst", 64'(bus.busy), 64'd1);
    chk("t9_seg_before_rst", 64'(bus.seg_idx), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t9_frq", 64'(bus.frq), 64'd0);
    chk("t9_gate", 64'(bus.tx_gate), 64'd0);
    chk("t9_busy", 64'(bus.busy), 64'd0);
    chk("t9_done", 64'(bus.done), 64'd0);
    chk("t9_seg", 64'(bus.seg_idx), 64'd0);
    chk("t9_rep", 64'(bus.rep_idx), 64'd0);

    run(2, 0, -1, 1'b0, 32'd0);
    chk("t10_busy_cycles", 64'(n_busy), 64'd41);
    chk("t10_gate_cycles", 64'(n_gate), 64'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
